serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing A - B - bin. It processes one bit per clock, LSB first, through a single 1-bit full-subtractor cell and keeps the borrow in a register between bits. It sits upstream of the result consumer and trades latency for area against a ripple array of full_subtractor cells. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B - bin), LSB first, one full-subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] d_next;
  logic             last_step;

  always_comb begin
    a_bit     = a_sr[0];
    b_bit     = b_sr[0];
    d_bit     = a_bit ^ b_bit ^ borrow;
    bo_bit    = (~a_bit & (b_bit | borrow)) | (b_bit & borrow);
    // New diff bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
    d_next    = (d_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_bout  <= 1'b0;
      borrow    <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      d_sr      <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            borrow   <= in_bin;
            cnt      <= '0;
            d_sr     <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= d_next;
          borrow <= bo_bit;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            out_diff  <= d_next;
            out_bout  <= bo_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
            out_ovf   <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed tests and WIDTH=4 exhaustive sweep.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid8, in_ready8, in_bin8, out_valid8, out_ready8, out_bout8;
  logic [7:0] in_a8, in_b8, out_diff8;
  logic       in_valid4, in_ready4, in_bin4, out_valid4, out_ready4, out_bout4;
  logic [3:0] in_a4, in_b4, out_diff4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       out_ovf8, out_ovf4;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_bin(in_bin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_diff(out_diff8), .out_bout(out_bout8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .out_ovf(out_ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_bin(in_bin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_diff(out_diff4), .out_bout(out_bout4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .out_ovf(out_ovf4)
`endif
  );

  // Drives one operand pair on the WIDTH=8 instance; expected {bout,diff} goes to q8.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic push);
    int t;
    logic [8:0] full;
    t = 0;
    while (!in_ready8 && t < 50) begin @(negedge clk); t++; end
    if (!in_ready8) begin
      n_cmp++; n_err++;
      $display("FAIL send8_ready: in_ready=%b required 1", in_ready8);
    end
    in_a8 = a; in_b8 = b; in_bin8 = bin; in_valid8 = 1'b1;
    full = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    if (push) q8.push_back(full);
    @(negedge clk);
    in_valid8 = 1'b0;
    in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_bin8 = 1'($urandom);
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int t;
    logic [3:0] d;
    logic       bo;
    t = 0;
    while (!in_ready4 && t < 50) begin @(negedge clk); t++; end
    if (!in_ready4) begin
      n_cmp++; n_err++;
      $display("FAIL send4_ready: in_ready=%b required 1", in_ready4);
    end
    in_a4 = a; in_b4 = b; in_bin4 = bin; in_valid4 = 1'b1;
    d  = 4'((int'(a) - int'(b) - int'(bin)) & 15);
    bo = (int'(a) < int'(b) + int'(bin));
    q4.push_back({bo, d});
    @(negedge clk);
    in_valid4 = 1'b0;
    in_a4 = 4'($urandom); in_b4 = 4'($urandom); in_bin4 = 1'($urandom);
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
    if (!out_valid8) begin
      n_cmp++; n_err++;
      $display("FAIL wait8_timeout: out_valid=%b required 1", out_valid8);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready8); end
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid8); end
    n_cmp++; if (out_diff8 !== 8'h00) begin n_err++; $display("FAIL reset_out_diff: got %h required 00", out_diff8); end
    n_cmp++; if (out_bout8 !== 1'b0) begin n_err++; $display("FAIL reset_out_bout: got %b required 0", out_bout8); end
    n_cmp++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      n_err++; $display("FAIL reset_dut4: in_ready=%b out_valid=%b required 1 0", in_ready4, out_valid4);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_cmp++; if (out_ovf8 !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b required 0", out_ovf8); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [16:0] vec [5] = '{ {8'h05, 8'h03, 1'b0}, {8'h03, 8'h05, 1'b0}, {8'h00, 8'h00, 1'b1},
                              {8'hFF, 8'hFF, 1'b0}, {8'h80, 8'h7F, 1'b1} };
    logic [8:0] exp;
    int lat;
    out_ready8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send8(vec[i][16:9], vec[i][8:1], vec[i][0], 1'b1);
      wait8(lat);
      n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL basic_latency[%0d]: got %0d required 8", i, lat); end
      exp = q8.pop_front();
      n_cmp++; if (out_diff8 !== exp[7:0]) begin n_err++; $display("FAIL basic_diff[%0d]: got %h required %h", i, out_diff8, exp[7:0]); end
      n_cmp++; if (out_bout8 !== exp[8]) begin n_err++; $display("FAIL basic_bout[%0d]: got %b required %b", i, out_bout8, exp[8]); end
      @(negedge clk);
      n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
        n_err++; $display("FAIL basic_release[%0d]: out_valid=%b in_ready=%b required 0 1", i, out_valid8, in_ready8);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] exp;
    int lat;
    out_ready8 = 1'b0;
    send8(8'h37, 8'h12, 1'b0, 1'b1);
    wait8(lat);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL bp_latency: got %0d required 8", lat); end
    exp = q8.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b required 1", i, out_valid8); end
      n_cmp++; if (in_ready8 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready8); end
      n_cmp++; if (out_diff8 !== exp[7:0]) begin n_err++; $display("FAIL bp_diff[%0d]: got %h required %h", i, out_diff8, exp[7:0]); end
      n_cmp++; if (out_bout8 !== exp[8]) begin n_err++; $display("FAIL bp_bout[%0d]: got %b required %b", i, out_bout8, exp[8]); end
      in_valid8 = 1'b1; in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_bin8 = 1'($urandom);
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_err++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready8, out_valid8);
    end
    send8(8'h10, 8'h01, 1'b0, 1'b1);
    wait8(lat);
    exp = q8.pop_front();
    n_cmp++; if (out_diff8 !== 8'h0F || out_diff8 !== exp[7:0]) begin
      n_err++; $display("FAIL bp_next_diff: got %h required 0f", out_diff8);
    end
    n_cmp++; if (out_bout8 !== 1'b0) begin n_err++; $display("FAIL bp_next_bout: got %b required 0", out_bout8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [8:0] exp;
    int lat;
    int seen;
    out_ready8 = 1'b1;
    send8(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b required 1", in_ready8); end
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b required 0", out_valid8); end
    n_cmp++; if (out_diff8 !== 8'h00) begin n_err++; $display("FAIL mid_out_diff: got %h required 00", out_diff8); end
    n_cmp++; if (out_bout8 !== 1'b0) begin n_err++; $display("FAIL mid_out_bout: got %b required 0", out_bout8); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8 === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_aborted_result: valid cycles=%0d required 0", seen); end
    send8(8'hAA, 8'h55, 1'b0, 1'b1);
    wait8(lat);
    exp = q8.pop_front();
    n_cmp++; if (out_diff8 !== 8'h55 || out_diff8 !== exp[7:0]) begin
      n_err++; $display("FAIL mid_retry_diff: got %h required 55", out_diff8);
    end
    n_cmp++; if (out_bout8 !== 1'b0) begin n_err++; $display("FAIL mid_retry_bout: got %b required 0", out_bout8); end
    @(negedge clk);
  endtask

  task automatic test_exhaustive4;
    logic [4:0] exp;
    int lat;
    out_ready4 = 1'b1;
    for (int v = 0; v < 512; v++) begin
      send4(4'(v >> 5), 4'(v >> 1), 1'(v));
      lat = 0;
      while (!out_valid4 && lat < 50) begin @(negedge clk); lat++; end
      exp = q4.pop_front();
      n_cmp++; if (out_valid4 !== 1'b1 || lat !== 4) begin
        n_err++; $display("FAIL exh_latency[%0d]: valid=%b lat=%0d required 1 4", v, out_valid4, lat);
      end
      n_cmp++; if (out_diff4 !== exp[3:0]) begin n_err++; $display("FAIL exh_diff[%0d]: got %h required %h", v, out_diff4, exp[3:0]); end
      n_cmp++; if (out_bout4 !== exp[4]) begin n_err++; $display("FAIL exh_bout[%0d]: got %b required %b", v, out_bout4, exp[4]); end
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_ovf;
    logic [16:0] vec [3] = '{ {8'h80, 8'h01, 1'b0}, {8'h7F, 8'hFF, 1'b0}, {8'h05, 8'h03, 1'b0} };
    logic        ovf [3] = '{1'b1, 1'b1, 1'b0};
    logic [8:0]  exp;
    int lat;
    out_ready8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send8(vec[i][16:9], vec[i][8:1], vec[i][0], 1'b1);
      wait8(lat);
      exp = q8.pop_front();
      n_cmp++; if (out_diff8 !== exp[7:0]) begin n_err++; $display("FAIL ovf_diff[%0d]: got %h required %h", i, out_diff8, exp[7:0]); end
      n_cmp++; if (out_ovf8 !== ovf[i]) begin n_err++; $display("FAIL ovf_flag[%0d]: got %b required %b", i, out_ovf8, ovf[i]); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_bin8 = 1'b0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_bin4 = 1'b0; out_ready4 = 1'b1;
    test_reset;
    test_basic;
    test_backpressure;
    test_reset_mid;
    test_exhaustive4;
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_ovf;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
